// File: rtl/vedic_pp_accum.sv
// Accumulates four Vedic partial products (aL*bL, aH*bL, aL*bH, aH*bH) into one
// 2*PP_W-bit product with overflow flag, using a valid/ready handshake on both sides.
module vedic_pp_accum #(
  parameter int PP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PP_W-1:0]   pp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*PP_W-1:0] product,
  output logic              ovf
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and the payload is held while valid waits for ready.

  localparam int PW = 2 * PP_W;
  localparam int AW = PW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    cnt;
  logic [AW-1:0] acc;
  logic [AW-1:0] pp_ext;
  logic [AW-1:0] weighted;
  logic          accept;

  assign accept = in_valid & in_ready;
  assign pp_ext = AW'(pp);

  // Beat weight follows its position: q0 x1, q1/q2 x2^(PP_W/2), q3 x2^PP_W.
  always_comb begin
    weighted = pp_ext;
    case (cnt)
      2'd0:    weighted = pp_ext;
      2'd1,
      2'd2:    weighted = pp_ext << (PP_W / 2);
      default: weighted = pp_ext << PP_W;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ACC;
      ACC:     if (accept && cnt == 2'd3) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (state)
      DONE:    begin in_ready = 1'b0; out_valid = 1'b1; end
      default: begin in_ready = 1'b1; out_valid = 1'b0; end
    endcase
  end

  // Datapath: the first beat loads rather than adds so stale results never leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 2'd0;
      acc <= '0;
    end else if (accept) begin
      if (state == IDLE) begin
        acc <= pp_ext;
        cnt <= 2'd1;
      end else begin
        acc <= acc + weighted;
        cnt <= cnt + 2'd1;
      end
    end else if (state == DONE && out_ready) begin
      cnt <= 2'd0;
    end
  end

  assign product = acc[PW-1:0];
  assign ovf     = acc[PW];

endmodule
